result_byte_streamer: RTL and testbench

- Downstream consumer of example_design. Captures each 16-bit `dout` result when `done` rises and buffers it in a small FIFO.
- Streams buffered results out MSB byte first over an 8-bit valid/ready interface. This interface feeds the UART/host link stage.
- Decouples the processing core from a slow byte sink. Overflow is reported, never silently hidden.

---
 rtl/result_byte_streamer.sv | 131 +++++++++++++
 tb/tb_result_byte_streamer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/result_byte_streamer.sv
// Captures each 16-bit result on the rising edge of done into a small FIFO and
// streams the buffered words out MSB byte first over an 8-bit valid/ready port.
module result_byte_streamer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    input  logic [DATA_W-1:0] dout,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              fifo_full,
    output logic              overflow,
    output logic              idle
);

    localparam int NBYTES = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state_q, state_d;
    logic               done_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               m_valid_q, m_valid_d;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic               idle_q, idle_d;
    logic               capture, push, pop;
    logic [DATA_W-1:0]  mem [DEPTH];

    always_comb begin
        capture  = done && !done_q;
        push     = capture && (count_q != FULL_CNT);
        pop      = 1'b0;
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    idx_d   = '0;
                    shift_d = mem[rd_ptr_q];
                    state_d = SEND;
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q << 8;
                    // Back-to-back words: reload at the last handshake so no bubble appears.
                    end else if (count_q != '0) begin
                        pop     = 1'b1;
                        idx_d   = '0;
                        shift_d = mem[rd_ptr_q];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        m_valid_d = (state_d == SEND);
        full_d    = (count_d == FULL_CNT);
        ovf_d     = ovf_q || (capture && (count_q == FULL_CNT));
        idle_d    = (state_d == IDLE) && (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            m_valid_q <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            done_q    <= done;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            m_valid_q <= m_valid_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            idle_q    <= idle_d;
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr_q] <= dout;
        end
    end

    assign m_data    = shift_q[DATA_W-1 -: 8];
    assign m_valid   = m_valid_q;
    assign fifo_full = full_q;
    assign overflow  = ovf_q;
    assign idle      = idle_q;

endmodule

// File: tb/tb_result_byte_streamer.sv
// Self-checking bench for result_byte_streamer: a per-cycle vector table plus
// hand-written overflow, push/pop overlap and mid-transfer reset sequences.
module tb_result_byte_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        done;
    logic [15:0] dout;
    logic        mReady;
    logic [7:0]  mData;
    logic        mValid;
    logic        fifoFull;
    logic        overflow;
    logic        idle;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic        rst;
        logic        dn;
        logic [15:0] dat;
        logic        rdy;
        logic        eValid;
        logic [7:0]  eData;
        logic        chkData;
        logic        eFull;
        logic        eOvf;
        logic        eIdle;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] gotBytes[$];
    logic [7:0] expBytes[$];

    result_byte_streamer #(.DATA_W(16), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .done      (done),
        .dout      (dout),
        .m_data    (mData),
        .m_valid   (mValid),
        .m_ready   (mReady),
        .fifo_full (fifoFull),
        .overflow  (overflow),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic addVec(input logic rst, input logic dn, input logic [15:0] dat,
                          input logic rdy, input logic eValid, input logic [7:0] eData,
                          input logic chkData, input logic eFull, input logic eOvf,
                          input logic eIdle);
        vec_t v;
        v.rst = rst; v.dn = dn; v.dat = dat; v.rdy = rdy;
        v.eValid = eValid; v.eData = eData; v.chkData = chkData;
        v.eFull = eFull; v.eOvf = eOvf; v.eIdle = eIdle;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic rst, input logic dn, input logic [15:0] dat,
                                 input logic rdy);
        @(negedge clk);
        reset  = rst;
        done   = dn;
        dout   = dat;
        mReady = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic eValid, input logic [7:0] eData,
                               input logic chkData, input logic eFull, input logic eOvf,
                               input logic eIdle);
        logic [11:0] actV;
        logic [11:0] expV;
        actV = {mValid, (chkData ? mData : 8'h00), fifoFull, overflow, idle};
        expV = {eValid, (chkData ? eData : 8'h00), eFull, eOvf, eIdle};
        testsRun++;
        if (actV !== expV) begin
            testsFailed++;
            $display("[TB] FAIL %s: got valid=%b data=%02h full=%b ovf=%b idle=%b, expected valid=%b data=%02h full=%b ovf=%b idle=%b",
                     name, mValid, mData, fifoFull, overflow, idle,
                     eValid, eData, eFull, eOvf, eIdle);
        end
    endtask

    initial begin
        int steps;
        reset  = 1'b0;
        done   = 1'b0;
        dout   = 16'h0000;
        mReady = 1'b0;

        // rst dn dat rdy | valid data chk full ovf idle
        addVec(0, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 1);
        addVec(0, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 1);
        // Single word, sink always ready
        addVec(1, 1, 16'hA55A, 1, 0, 8'h00, 0, 0, 0, 0);
        addVec(1, 0, 16'h0000, 1, 1, 8'hA5, 1, 0, 0, 0);
        addVec(1, 0, 16'h0000, 1, 1, 8'h5A, 1, 0, 0, 0);
        addVec(1, 0, 16'h0000, 1, 0, 8'h00, 0, 0, 0, 1);
        // Stall with m_ready low for 5 cycles
        addVec(1, 1, 16'h1234, 0, 0, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) addVec(1, 0, 16'h0000, 0, 1, 8'h12, 1, 0, 0, 0);
        addVec(1, 0, 16'h0000, 1, 1, 8'h34, 1, 0, 0, 0);
        addVec(1, 0, 16'h0000, 1, 0, 8'h00, 0, 0, 0, 1);
        // done held high for 10 cycles gives one capture
        addVec(1, 1, 16'hBEEF, 1, 0, 8'h00, 0, 0, 0, 0);
        addVec(1, 1, 16'hBEEF, 1, 1, 8'hBE, 1, 0, 0, 0);
        addVec(1, 1, 16'hBEEF, 1, 1, 8'hEF, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) addVec(1, 1, 16'hBEEF, 1, 0, 8'h00, 0, 0, 0, 1);
        addVec(1, 0, 16'h0000, 1, 0, 8'h00, 0, 0, 0, 1);
        // Captures on alternate cycles stream without gaps
        addVec(1, 1, 16'h0102, 1, 0, 8'h00, 0, 0, 0, 0);
        addVec(1, 0, 16'h0000, 1, 1, 8'h01, 1, 0, 0, 0);
        addVec(1, 1, 16'h0304, 1, 1, 8'h02, 1, 0, 0, 0);
        addVec(1, 0, 16'h0000, 1, 1, 8'h03, 1, 0, 0, 0);
        addVec(1, 1, 16'h0506, 1, 1, 8'h04, 1, 0, 0, 0);
        addVec(1, 0, 16'h0000, 1, 1, 8'h05, 1, 0, 0, 0);
        addVec(1, 0, 16'h0000, 1, 1, 8'h06, 1, 0, 0, 0);
        addVec(1, 0, 16'h0000, 1, 0, 8'h00, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].dn, vecs[i].dat, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eData,
                        vecs[i].chkData, vecs[i].eFull, vecs[i].eOvf, vecs[i].eIdle);
        end

        // Six pulses while stalled: word 1 sits in the shifter, 2..5 fill the FIFO, 6 drops.
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1, 1, 16'(k), 0);
            if (k == 4) checkOutput("ovf_cap4", 1, 8'h00, 1, 0, 0, 0);
            if (k == 5) checkOutput("ovf_cap5_full", 1, 8'h00, 1, 1, 0, 0);
            if (k == 6) checkOutput("ovf_cap6_drop", 1, 8'h00, 1, 1, 1, 0);
            applyStimulus(1, 0, 16'h0000, 0);
        end

        // Drain; a capture at step 3 coincides with a last-byte pop.
        expBytes = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04,
                     8'h00, 8'h05, 8'h06, 8'h07};
        steps = 0;
        while (mValid && steps < 40) begin
            gotBytes.push_back(mData);
            applyStimulus(1, (steps == 3), 16'h0607, 1);
            steps++;
        end
        testsRun++;
        if (mValid) begin
            testsFailed++;
            $display("[TB] FAIL drain_timeout: m_valid=%b after %0d steps, required 0", mValid, steps);
        end
        testsRun++;
        if (gotBytes.size() != expBytes.size()) begin
            testsFailed++;
            $display("[TB] FAIL drain_count: got %0d bytes, expected %0d", gotBytes.size(), expBytes.size());
        end
        for (int i = 0; i < expBytes.size() && i < gotBytes.size(); i++) begin
            testsRun++;
            if (gotBytes[i] !== expBytes[i]) begin
                testsFailed++;
                $display("[TB] FAIL drain_byte%0d: got %02h, expected %02h", i, gotBytes[i], expBytes[i]);
            end
        end
        checkOutput("ovf_sticky", 0, 8'h00, 0, 0, 1, 1);

        // Reset in the middle of a word with two more buffered
        applyStimulus(0, 0, 16'h0000, 0);
        checkOutput("reset_clears_ovf", 0, 8'h00, 1, 0, 0, 1);
        applyStimulus(1, 1, 16'hA55A, 0);
        applyStimulus(1, 0, 16'h0000, 0);
        applyStimulus(1, 1, 16'h1111, 0);
        applyStimulus(1, 0, 16'h0000, 0);
        applyStimulus(1, 1, 16'h2222, 0);
        applyStimulus(1, 0, 16'h0000, 0);
        checkOutput("mid_stall", 1, 8'hA5, 1, 0, 0, 0);
        applyStimulus(1, 0, 16'h0000, 1);
        checkOutput("mid_byte2", 1, 8'h5A, 1, 0, 0, 0);
        applyStimulus(0, 0, 16'h0000, 1);
        checkOutput("mid_reset", 0, 8'h00, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 16'h0000, 1);
            checkOutput($sformatf("post_reset_quiet%0d", i), 0, 8'h00, 0, 0, 0, 1);
        end
        applyStimulus(1, 1, 16'h7788, 1);
        checkOutput("new_cap", 0, 8'h00, 0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0000, 1);
        checkOutput("new_msb", 1, 8'h77, 1, 0, 0, 0);
        applyStimulus(1, 0, 16'h0000, 1);
        checkOutput("new_lsb", 1, 8'h88, 1, 0, 0, 0);
        applyStimulus(1, 0, 16'h0000, 1);
        checkOutput("new_done", 0, 8'h00, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
